// File: rtl/alu_rr_pkg.sv
// Shared definitions for the register-register ALU control sequencer:
// opcodes, FSM state encoding, IR field positions and decode helpers.
package alu_rr_pkg;

  localparam int IR_W = 32;

  typedef logic [4:0] opcode_t;

  localparam opcode_t OPC_ADD  = 5'b00011;
  localparam opcode_t OPC_SUB  = 5'b00100;
  localparam opcode_t OPC_SHR  = 5'b00101;
  localparam opcode_t OPC_SHL  = 5'b00110;
  localparam opcode_t OPC_ROR  = 5'b00111;
  localparam opcode_t OPC_ROL  = 5'b01000;
  localparam opcode_t OPC_AND  = 5'b01001;
  localparam opcode_t OPC_OR   = 5'b01010;
  localparam opcode_t OPC_MUL  = 5'b01111;
  localparam opcode_t OPC_DIV  = 5'b10000;
  localparam opcode_t OPC_HALT = 5'b11011;

  typedef enum logic [3:0] {
    S_IDLE = 4'd0,
    S_T0   = 4'd1,
    S_T1   = 4'd2,
    S_T2   = 4'd3,
    S_T3   = 4'd4,
    S_T4   = 4'd5,
    S_T5   = 4'd6,
    S_T6   = 4'd7,
    S_HALT = 4'd8,
    S_TRAP = 4'd9
  } state_t;

  // Register fields follow the opcode back-to-back: idx 0 = Ra, 1 = Rb, 2 = Rc.
  function automatic int field_lsb(input int opc_w, input int sel_w, input int idx);
    return IR_W - opc_w - (idx + 1) * sel_w;
  endfunction

  function automatic logic is_muldiv(input opcode_t op);
    return (op == OPC_MUL) || (op == OPC_DIV);
  endfunction

  // Halt is decoded separately and is not counted as a legal ALU operation.
  function automatic logic is_legal(input opcode_t op);
    case (op)
      OPC_ADD, OPC_SUB, OPC_SHR, OPC_SHL, OPC_ROR,
      OPC_ROL, OPC_AND, OPC_OR, OPC_MUL, OPC_DIV: return 1'b1;
      default:                                    return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/alu_rr_sequencer_reg_sel_decoder.sv
// Register index plus enable to one-hot select lines for the register file.
module reg_sel_decoder #(
  parameter int SEL_W = 4
) (
  input  logic [SEL_W-1:0]    sel,
  input  logic                en,
  output logic [2**SEL_W-1:0] onehot
);

  // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and infers a latch.
  always_comb begin
    onehot = '0;
    if (en) onehot[sel] = 1'b1;
  end

endmodule

// File: rtl/alu_rr_sequencer.sv
// Hardwired control FSM for register-register ALU instructions: fetch with a
// memory-ready handshake, decode, execute, HI/LO writeback, halt/illegal traps.
module alu_rr_sequencer
  import alu_rr_pkg::*;
#(
  parameter int REG_SEL_W = 4,
  parameter int OPC_W     = 5,
  parameter int CNT_W     = 16,
  localparam int NUM_REGS = 2**REG_SEL_W
) (
  input  logic                Clock,
  input  logic                Clear,
  input  logic                Run,
  input  logic                Mem_ready,
  input  logic [IR_W-1:0]     IR_in,
  output logic                PCout,
  output logic                Zlowout,
  output logic                ZHighout,
  output logic                MDRout,
  output logic                MARin,
  output logic                PCin,
  output logic                MDRin,
  output logic                IRin,
  output logic                Yin,
  output logic                ZLowIn,
  output logic                ZHighIn,
  output logic                HIin,
  output logic                LOin,
  output logic                IncPC,
  output logic                Read,
  output logic [OPC_W-1:0]    ALU_op,
  output logic [NUM_REGS-1:0] Rout,
  output logic [NUM_REGS-1:0] Rin,
  output logic                Done,
  output logic                Halted,
  output logic                Illegal,
  output logic [CNT_W-1:0]    Instr_count,
  output logic [3:0]          State
);

  localparam int RA_LSB = field_lsb(OPC_W, REG_SEL_W, 0);
  localparam int RB_LSB = field_lsb(OPC_W, REG_SEL_W, 1);
  localparam int RC_LSB = field_lsb(OPC_W, REG_SEL_W, 2);

  state_t               state, state_nx;
  logic                 t1_first;
  logic [CNT_W-1:0]     count;
  logic [OPC_W-1:0]     opc;
  logic                 legal, muldiv, halt_op;
  logic [REG_SEL_W-1:0] rout_sel;
  logic                 rout_en, rin_en;
  logic                 unused_ir_bits;

  assign opc     = IR_in[IR_W-1 -: OPC_W];
  assign legal   = is_legal(opcode_t'(opc));
  assign muldiv  = is_muldiv(opcode_t'(opc));
  assign halt_op = (opcode_t'(opc) == OPC_HALT);
  assign unused_ir_bits = ^IR_in[RC_LSB-1:0];

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge Clock or negedge Clear) begin
    if (!Clear) begin
      state    <= S_IDLE;
      t1_first <= 1'b0;
      count    <= '0;
    end else begin
      state    <= state_nx;
      // Only the cycle right after T0 is the first cycle of T1.
      t1_first <= (state == S_T0);
      if (Done) count <= count + CNT_W'(1);
    end
  end

  always_comb begin
    state_nx = state;
    PCout    = 1'b0;  Zlowout = 1'b0;  ZHighout = 1'b0;  MDRout = 1'b0;
    MARin    = 1'b0;  PCin    = 1'b0;  MDRin    = 1'b0;  IRin   = 1'b0;
    Yin      = 1'b0;  ZLowIn  = 1'b0;  ZHighIn  = 1'b0;  HIin   = 1'b0;
    LOin     = 1'b0;  IncPC   = 1'b0;  Read     = 1'b0;  Done   = 1'b0;
    Halted   = 1'b0;  Illegal = 1'b0;  ALU_op   = '0;
    rout_en  = 1'b0;  rin_en  = 1'b0;
    rout_sel = IR_in[RC_LSB +: REG_SEL_W];
    case (state)
      S_IDLE: if (Run) state_nx = S_T0;
      S_T0: begin
        PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1; ZLowIn = 1'b1;
        state_nx = S_T1;
      end
      S_T1: begin
        Zlowout = 1'b1; Read = 1'b1; MDRin = 1'b1;
        PCin    = t1_first;
        if (Mem_ready) state_nx = S_T2;
      end
      S_T2: begin
        MDRout = 1'b1; IRin = 1'b1;
        state_nx = S_T3;
      end
      S_T3: begin
        if (halt_op)     state_nx = S_HALT;
        else if (!legal) state_nx = S_TRAP;
        else begin
          rout_en  = 1'b1;
          rout_sel = IR_in[RB_LSB +: REG_SEL_W];
          Yin      = 1'b1;
          state_nx = S_T4;
        end
      end
      S_T4: begin
        rout_en = 1'b1; ALU_op = opc; ZLowIn = 1'b1; ZHighIn = muldiv;
        state_nx = S_T5;
      end
      S_T5: begin
        Zlowout = 1'b1;
        if (muldiv) begin
          LOin     = 1'b1;
          state_nx = S_T6;
        end else begin
          rin_en   = 1'b1;
          Done     = 1'b1;
          state_nx = Run ? S_T0 : S_IDLE;
        end
      end
      S_T6: begin
        ZHighout = 1'b1; HIin = 1'b1; Done = 1'b1;
        state_nx = Run ? S_T0 : S_IDLE;
      end
      S_HALT:  Halted  = 1'b1;
      S_TRAP:  Illegal = 1'b1;
      default: state_nx = S_IDLE;
    endcase
  end

  reg_sel_decoder #(.SEL_W(REG_SEL_W)) u_rout_dec (
    .sel    (rout_sel),
    .en     (rout_en),
    .onehot (Rout)
  );

  reg_sel_decoder #(.SEL_W(REG_SEL_W)) u_rin_dec (
    .sel    (IR_in[RA_LSB +: REG_SEL_W]),
    .en     (rin_en),
    .onehot (Rin)
  );

  assign Instr_count = count;
  assign State       = state;

endmodule

// File: tb/tb_alu_rr_sequencer.sv
// Bench for alu_rr_sequencer: a transaction-level model expands each issued
// instruction into its expected per-cycle control vectors; a compare process checks them.
module tb_alu_rr_sequencer;
  import alu_rr_pkg::*;

  logic        Clock = 1'b0, Clear = 1'b1, Run = 1'b0, Mem_ready = 1'b0;
  logic [31:0] IR_in = '0;

  logic        PCout, Zlowout, ZHighout, MDRout, MARin, PCin, MDRin, IRin, Yin;
  logic        ZLowIn, ZHighIn, HIin, LOin, IncPC, Read, Done, Halted, Illegal;
  logic [4:0]  ALU_op;
  logic [15:0] Rout, Rin, Instr_count;
  logic [3:0]  State;

  logic        w2_PCout, w2_Zlowout, w2_ZHighout, w2_MDRout, w2_MARin, w2_PCin, w2_MDRin;
  logic        w2_IRin, w2_Yin, w2_ZLowIn, w2_ZHighIn, w2_HIin, w2_LOin, w2_IncPC, w2_Read;
  logic        w2_Done, w2_Halted, w2_Illegal;
  logic [4:0]  w2_ALU_op;
  logic [15:0] w2_Rout, w2_Rin;
  logic [1:0]  w2_count;
  logic [3:0]  w2_State;

  alu_rr_sequencer dut (
    .Clock(Clock), .Clear(Clear), .Run(Run), .Mem_ready(Mem_ready), .IR_in(IR_in),
    .PCout(PCout), .Zlowout(Zlowout), .ZHighout(ZHighout), .MDRout(MDRout),
    .MARin(MARin), .PCin(PCin), .MDRin(MDRin), .IRin(IRin), .Yin(Yin),
    .ZLowIn(ZLowIn), .ZHighIn(ZHighIn), .HIin(HIin), .LOin(LOin),
    .IncPC(IncPC), .Read(Read), .ALU_op(ALU_op), .Rout(Rout), .Rin(Rin),
    .Done(Done), .Halted(Halted), .Illegal(Illegal),
    .Instr_count(Instr_count), .State(State)
  );

  alu_rr_sequencer #(.CNT_W(2)) dut_w2 (
    .Clock(Clock), .Clear(Clear), .Run(Run), .Mem_ready(Mem_ready), .IR_in(IR_in),
    .PCout(w2_PCout), .Zlowout(w2_Zlowout), .ZHighout(w2_ZHighout), .MDRout(w2_MDRout),
    .MARin(w2_MARin), .PCin(w2_PCin), .MDRin(w2_MDRin), .IRin(w2_IRin), .Yin(w2_Yin),
    .ZLowIn(w2_ZLowIn), .ZHighIn(w2_ZHighIn), .HIin(w2_HIin), .LOin(w2_LOin),
    .IncPC(w2_IncPC), .Read(w2_Read), .ALU_op(w2_ALU_op), .Rout(w2_Rout), .Rin(w2_Rin),
    .Done(w2_Done), .Halted(w2_Halted), .Illegal(w2_Illegal),
    .Instr_count(w2_count), .State(w2_State)
  );

  always #5 Clock = ~Clock;

  typedef struct packed {
    logic pcout, zlowout, zhighout, mdrout, marin, pcin, mdrin, irin, yin;
    logic zlowin, zhighin, hiin, loin, incpc, read, done, halted, illegal;
    logic [4:0]  alu_op;
    logic [15:0] rout, rin;
    logic [3:0]  state;
  } vec_t;

  vec_t act, w2_act, exp_r, last_act;
  logic exp_valid = 1'b0;
  int   checks = 0, failures = 0;
  int   model_count = 0;
  bit   in_idle = 1'b1;
  int   ncyc, pcin_hits;
  bit   rin_ever;
  vec_t snap [16];

  logic [4:0] legal_ops [10] = '{5'b00011, 5'b00100, 5'b00101, 5'b00110, 5'b00111,
                                 5'b01000, 5'b01001, 5'b01010, 5'b01111, 5'b10000};
  int w2_seq [5] = '{1, 2, 3, 0, 1};

  assign act = {PCout, Zlowout, ZHighout, MDRout, MARin, PCin, MDRin, IRin, Yin,
                ZLowIn, ZHighIn, HIin, LOin, IncPC, Read, Done, Halted, Illegal,
                ALU_op, Rout, Rin, State};
  assign w2_act = {w2_PCout, w2_Zlowout, w2_ZHighout, w2_MDRout, w2_MARin, w2_PCin,
                   w2_MDRin, w2_IRin, w2_Yin, w2_ZLowIn, w2_ZHighIn, w2_HIin, w2_LOin,
                   w2_IncPC, w2_Read, w2_Done, w2_Halted, w2_Illegal,
                   w2_ALU_op, w2_Rout, w2_Rin, w2_State};

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s: got=%h want=%h (t=%0t)", name, got, want, $time);
    end
  endtask

  function automatic bit legal(input logic [4:0] op);
    return op inside {5'b00011, 5'b00100, 5'b00101, 5'b00110, 5'b00111,
                      5'b01000, 5'b01001, 5'b01010, 5'b01111, 5'b10000};
  endfunction

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  // Expected control vector for one cycle of the instruction in ir.
  function automatic vec_t mk(input state_t s, input logic [31:0] ir, input logic first);
    vec_t e = '0;
    logic [4:0] op = ir[31:27];
    bit md = (op == 5'b01111) || (op == 5'b10000);
    e.state = s;
    case (s)
      S_T0: begin e.pcout = 1; e.marin = 1; e.incpc = 1; e.zlowin = 1; end
      S_T1: begin e.zlowout = 1; e.read = 1; e.mdrin = 1; e.pcin = first; end
      S_T2: begin e.mdrout = 1; e.irin = 1; end
      S_T3: if (legal(op)) begin e.rout = 16'h1 << ir[22:19]; e.yin = 1; end
      S_T4: begin e.rout = 16'h1 << ir[18:15]; e.alu_op = op; e.zlowin = 1; e.zhighin = md; end
      S_T5: begin
        e.zlowout = 1;
        if (md) e.loin = 1;
        else begin e.rin = 16'h1 << ir[26:23]; e.done = 1; end
      end
      S_T6:   begin e.zhighout = 1; e.hiin = 1; e.done = 1; end
      S_HALT: e.halted = 1;
      S_TRAP: e.illegal = 1;
      default: ;
    endcase
    return e;
  endfunction

  always @(negedge Clock) begin
    last_act = act;
    if (exp_valid && Clear) begin
      check("outputs", 64'(act), 64'(exp_r));
      check("w2_outputs", 64'(w2_act), 64'(exp_r));
      check("instr_count", 64'(Instr_count), 64'(model_count[15:0]));
      check("w2_count", 64'(w2_count), 64'(model_count[1:0]));
      check("bus_drive_le1", 64'($countones({PCout, Zlowout, ZHighout, MDRout, Rout}) <= 1), 64'd1);
    end
  end

  // One clock cycle: drive inputs, publish expectation, advance.
  task automatic cyc(input vec_t e, input logic mr, input logic run);
    Mem_ready = mr;
    Run       = run;
    exp_r     = e;
    exp_valid = 1'b1;
    @(posedge Clock); #1;
    if (e.done) model_count++;
    snap[e.state] = last_act;
    ncyc++;
    pcin_hits += int'(last_act.pcin);
    if (|last_act.rin) rin_ever = 1'b1;
  endtask

  task automatic check_cleared(input string tag);
    check({tag, "_outs"}, 64'(act[58:4]), 64'd0);
    check({tag, "_state"}, 64'(State), 64'(S_IDLE));
    check({tag, "_count"}, 64'(Instr_count), 64'd0);
  endtask

  task automatic do_reset();
    exp_valid = 1'b0;
    #2 Clear = 1'b0;
    #1 check_cleared("reset");
    @(posedge Clock); #1;
    Clear       = 1'b1;
    model_count = 0;
    in_idle     = 1'b1;
  endtask

  task automatic run_instr(input logic [31:0] ir, input int waits, input logic run_after,
                           input bit abort_t4);
    logic [4:0] op = ir[31:27];
    bit md = (op == 5'b01111) || (op == 5'b10000);
    if (in_idle) begin
      repeat ($urandom_range(0, 2)) cyc(mk(S_IDLE, IR_in, 0), rb(), 1'b0);
      cyc(mk(S_IDLE, IR_in, 0), rb(), 1'b1);
    end
    ncyc = 0; pcin_hits = 0; rin_ever = 1'b0;
    cyc(mk(S_T0, IR_in, 0), rb(), rb());
    for (int k = 0; k <= waits; k++) cyc(mk(S_T1, IR_in, k == 0), k == waits, rb());
    cyc(mk(S_T2, IR_in, 0), rb(), rb());
    IR_in = ir;
    cyc(mk(S_T3, ir, 0), rb(), rb());
    if (!legal(op)) return;
    if (abort_t4) begin
      Mem_ready = rb(); Run = rb();
      exp_r = mk(S_T4, ir, 0); exp_valid = 1'b1;
      @(negedge Clock); #2;
      exp_valid = 1'b0;
      Clear = 1'b0;
      #1 check_cleared("clear_mid_t4");
      @(posedge Clock); #1;
      Clear = 1'b1; model_count = 0; in_idle = 1'b1;
      return;
    end
    cyc(mk(S_T4, ir, 0), rb(), rb());
    if (md) begin
      cyc(mk(S_T5, ir, 0), rb(), rb());
      cyc(mk(S_T6, ir, 0), rb(), run_after);
    end else begin
      cyc(mk(S_T5, ir, 0), rb(), run_after);
    end
    in_idle = !run_after;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
    do_reset();

    // and R5,R2,R4 with memory ready immediately
    run_instr(32'h4A920000, 0, 1'b0, 1'b0);
    check("and_cycles", 64'(ncyc), 64'd6);
    check("and_t3_rout", 64'(snap[S_T3].rout), 64'h0004);
    check("and_t4_rout", 64'(snap[S_T4].rout), 64'h0010);
    check("and_t4_aluop", 64'(snap[S_T4].alu_op), 64'b01001);
    check("and_t5_rin", 64'(snap[S_T5].rin), 64'h0020);
    check("and_t5_done", 64'(snap[S_T5].done), 64'd1);
    check("and_count", 64'(Instr_count), 64'd1);

    // same instruction, memory stalls three cycles
    run_instr(32'h4A920000, 3, 1'b0, 1'b0);
    check("stall_cycles", 64'(ncyc), 64'd9);
    check("stall_pcin_once", 64'(pcin_hits), 64'd1);

    // mul: HI/LO writeback, no register-file write
    run_instr(32'h7A920000, 1, 1'b1, 1'b0);
    check("mul_t4_zlow_zhigh", 64'({snap[S_T4].zlowin, snap[S_T4].zhighin}), 64'b11);
    check("mul_t5_loin", 64'(snap[S_T5].loin), 64'd1);
    check("mul_t6_hi_zh_done", 64'({snap[S_T6].hiin, snap[S_T6].zhighout, snap[S_T6].done}), 64'b111);
    check("mul_no_rin", 64'(rin_ever), 64'd0);

    repeat (80)
      run_instr({legal_ops[$urandom_range(0, 9)], 27'($urandom)}, $urandom_range(0, 3),
                1'($urandom_range(0, 3) != 0), 1'b0);

    // 2-bit counter wraps across five back-to-back adds
    do_reset();
    for (int i = 0; i < 5; i++) begin
      run_instr({5'b00011, 27'($urandom)}, $urandom_range(0, 1), 1'b1, 1'b0);
      check("w2_wrap_seq", 64'(w2_count), 64'(w2_seq[i]));
    end

    // halt is terminal and ignores Run
    do_reset();
    run_instr({5'b11011, 27'($urandom)}, 0, 1'b1, 1'b0);
    repeat (6) cyc(mk(S_HALT, IR_in, 0), rb(), rb());
    check("halted_sticky", 64'(Halted), 64'd1);
    do_reset();
    check("halt_cleared", 64'(Halted), 64'd0);

    // illegal opcode traps, then clear lands mid-instruction
    run_instr({5'b11111, 27'($urandom)}, 1, 1'b1, 1'b0);
    repeat (5) cyc(mk(S_TRAP, IR_in, 0), rb(), rb());
    check("illegal_sticky", 64'(Illegal), 64'd1);
    do_reset();
    check("illegal_cleared", 64'(Illegal), 64'd0);
    run_instr({5'b00011, 27'($urandom)}, 0, 1'b1, 1'b0);
    run_instr({5'b00011, 27'($urandom)}, 0, 1'b1, 1'b1);
    run_instr({5'b00100, 27'($urandom)}, 2, 1'b0, 1'b0);
    check("recover_count", 64'(Instr_count), 64'd1);

    exp_valid = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
